// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with control decode, handshakes and iterative shift-add multiplier
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_EN  = 1,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]    mplier_q, mplier_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]    dec_result;
    logic               dec_illegal;
    logic               dec_mul;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic [XLEN-1:0]    acc_step;

    assign shamt     = op_b[SHAMT_W-1:0];
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == ST_MUL);

    // Decode the control fields and compute every single-cycle result; MUL only raises dec_mul
    always_comb begin
        dec_result  = '0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        case (alu_op)
            2'b00: dec_result = op_a + op_b;
            2'b01: dec_result = op_a - op_b;
            2'b10: begin
                if (!funct7_0) begin
                    case (funct3)
                        3'b000: dec_result = funct7_5 ? (op_a - op_b) : (op_a + op_b);
                        3'b111: dec_result = op_a & op_b;
                        3'b110: dec_result = op_a | op_b;
                        3'b100: dec_result = op_a ^ op_b;
                        3'b001: dec_result = op_a << shamt;
                        3'b101: dec_result = funct7_5 ? XLEN'($signed(op_a) >>> shamt)
                                                      : (op_a >> shamt);
                        3'b010: dec_result = XLEN'($signed(op_a) < $signed(op_b));
                        3'b011: dec_result = XLEN'(op_a < op_b);
                        default: dec_illegal = 1'b1;
                    endcase
                end else if ((funct3 == 3'b000) && (MUL_EN != 0)) begin
                    dec_mul = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: begin
                if (funct3 == 3'b000) begin
                    dec_result = op_a << 1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
        endcase
    end

    // Next-state: accept/retire in IDLE, one shift-add step per cycle in MUL
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (dec_mul) begin
                        acc_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        result_d    = dec_result;
                        zero_d      = (dec_result == '0);
                        illegal_d   = dec_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last step folds directly into the result so latency is exactly XLEN
                if (cnt_q == CNT_LAST) begin
                    result_d    = acc_step;
                    zero_d      = (acc_step == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic        funct7_0 = 1'b0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    logic        u2_in_valid = 1'b0;
    logic        u2_in_ready;
    logic [1:0]  u2_alu_op = 2'b00;
    logic [2:0]  u2_funct3 = 3'b000;
    logic        u2_funct7_5 = 1'b0;
    logic        u2_funct7_0 = 1'b0;
    logic [31:0] u2_op_a = 32'h0;
    logic [31:0] u2_op_b = 32'h0;
    logic        u2_out_valid;
    logic        u2_out_ready = 1'b1;
    logic [31:0] u2_result;
    logic        u2_zero;
    logic        u2_illegal;
    logic        u2_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .busy(busy)
    );

    alu_exec_unit #(.XLEN(32), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u2_in_valid), .in_ready(u2_in_ready),
        .alu_op(u2_alu_op), .funct3(u2_funct3), .funct7_5(u2_funct7_5), .funct7_0(u2_funct7_0),
        .op_a(u2_op_a), .op_b(u2_op_b),
        .out_valid(u2_out_valid), .out_ready(u2_out_ready),
        .result(u2_result), .zero(u2_zero), .illegal(u2_illegal), .busy(u2_busy)
    );

    // Reference model: instruction semantics in plain arithmetic
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f75, input logic f70,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input bit mul_en, output bit ill, output bit is_mul);
        logic [63:0] prod;
        int sh;
        int sa;
        int sb;
        ill = 1'b0;
        is_mul = 1'b0;
        sh = int'(b[4:0]);
        sa = int'(a);
        sb = int'(b);
        ref_alu = 32'h0;
        if (op == 2'd0) begin
            ref_alu = a + b;
        end else if (op == 2'd1) begin
            ref_alu = a - b;
        end else if (op == 2'd3) begin
            if (f3 == 3'd0) ref_alu = a * 32'd2;
            else ill = 1'b1;
        end else if (f70) begin
            if (f3 == 3'd0 && mul_en) begin
                is_mul = 1'b1;
                prod = {32'h0, a} * {32'h0, b};
                ref_alu = prod[31:0];
            end else begin
                ill = 1'b1;
            end
        end else begin
            case (f3)
                3'd0: ref_alu = f75 ? a - b : a + b;
                3'd7: ref_alu = a & b;
                3'd6: ref_alu = a | b;
                3'd4: ref_alu = a ^ b;
                3'd1: ref_alu = a << sh;
                3'd5: ref_alu = (f75 && a[31]) ? ~((~a) >> sh) : (a >> sh);
                3'd2: ref_alu = (sa < sb) ? 32'd1 : 32'd0;
                default: ref_alu = (a < b) ? 32'd1 : 32'd0;
            endcase
        end
    endfunction

    task automatic set_req(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                           input logic f70, input logic [31:0] a, input logic [31:0] b);
        alu_op = op;
        funct3 = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        op_a = a;
        op_b = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ov=%b busy=%b res=%h zero=%b ill=%b, required 0 0 0 0 0",
                     out_valid, busy, result, zero, illegal);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [2:0]  f3s [5] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b000};
        logic        f75s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] as [5] = '{32'd5, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h4000_0001};
        logic [31:0] bs [5] = '{32'd7, 32'd5, 32'd4, 32'd1, 32'd0};
        logic [31:0] exps [5] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'h8000_0002};
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            set_req(ops[i], f3s[i], f75s[i], 1'b0, as[i], bs[i]);
            in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== exps[i] || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: ov=%b res=%h ill=%b, required 1 %h 0",
                         i, out_valid, result, illegal, exps[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || result !== exps[4]) begin
            miscompares++;
            $display("FAIL b2b_retire_hold: ov=%b res=%h, required 0 %h", out_valid, result, exps[4]);
        end
    endtask

    task automatic test_mul();
        logic [31:0] as [2] = '{32'h0001_0003, 32'hFFFF_FFFF};
        logic [31:0] bs [2] = '{32'h0000_0005, 32'hFFFF_FFFF};
        logic [31:0] exps [2] = '{32'h0005_000F, 32'h0000_0001};
        int bad;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_req(2'b10, 3'b000, 1'b0, 1'b1, as[i], bs[i]);
            in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mul_accept_ready[%0d]: got %b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
            set_req(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
            bad = 0;
            for (int k = 1; k <= 32; k++) begin
                #1;
                vectors++;
                if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    bad++;
                    miscompares++;
                    if (bad < 4)
                        $display("FAIL mul_inflight[%0d] cycle %0d: busy=%b ov=%b ir=%b, required 1 0 0",
                                 i, k, busy, out_valid, in_ready);
                end
                @(posedge clk); #1;
            end
            vectors++;
            if (out_valid !== 1'b1 || result !== exps[i] || busy !== 1'b0 || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL mul_result[%0d]: ov=%b res=%h busy=%b ill=%b, required 1 %h 0 0",
                         i, out_valid, result, busy, illegal, exps[i]);
            end
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        set_req(2'b00, 3'b000, 1'b0, 1'b0, 32'd20, 32'd22);
        in_valid = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'd42) begin
            miscompares++;
            $display("FAIL bp_first: ov=%b res=%h, required 1 0000002a", out_valid, result);
        end
        out_ready = 1'b0;
        set_req(2'b01, 3'b000, 1'b0, 1'b0, 32'd100, 32'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_in_ready[%0d]: got %b, required 0", k, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== 32'd42 || zero !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: ov=%b res=%h zero=%b, required 1 0000002a 0",
                         k, out_valid, result, zero);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || result !== 32'd99) begin
            miscompares++;
            $display("FAIL bp_retire_accept: ov=%b res=%h, required 1 00000063", out_valid, result);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_zero();
        out_ready = 1'b1;
        set_req(2'b10, 3'b111, 1'b0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F);
        in_valid = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_flag: ov=%b ill=%b res=%h zero=%b, required 1 1 0 1",
                     out_valid, illegal, result, zero);
        end
        set_req(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9);
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || illegal !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_zero: ov=%b ill=%b res=%h zero=%b, required 1 0 0 1",
                     out_valid, illegal, result, zero);
        end
        in_valid = 1'b0;
        u2_alu_op = 2'b10;
        u2_funct3 = 3'b000;
        u2_funct7_5 = 1'b0;
        u2_funct7_0 = 1'b1;
        u2_op_a = 32'd6;
        u2_op_b = 32'd7;
        u2_out_ready = 1'b1;
        u2_in_valid = 1'b1;
        @(posedge clk); #1;
        u2_in_valid = 1'b0;
        vectors++;
        if (u2_out_valid !== 1'b1 || u2_illegal !== 1'b1 || u2_result !== 32'h0 || u2_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nomul_illegal: ov=%b ill=%b res=%h busy=%b, required 1 1 0 0",
                     u2_out_valid, u2_illegal, u2_result, u2_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        set_req(2'b00, 3'b000, 1'b0, 1'b0, 32'h11, 32'h22);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_req(2'b10, 3'b000, 1'b0, 1'b1, 32'h1234, 32'h5678);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || result !== 32'h33) begin
            miscompares++;
            $display("FAIL midmul_pre: busy=%b ov=%b res=%h, required 1 0 00000033", busy, out_valid, result);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL midmul_reset: ov=%b busy=%b res=%h, required 0 0 0", out_valid, busy, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midmul_in_ready: got %b, required 1", in_ready);
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL midmul_abandon[%0d]: ov=%b busy=%b, required 0 0", k, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        bit          mv = 1'b0;
        bit          mill = 1'b0;
        bit          mzero = 1'b0;
        logic [31:0] mres = 32'h0;
        logic [31:0] mpend = 32'h0;
        int          mcnt = 0;
        bit          exp_ir;
        bit          acc;
        bit          ill;
        bit          is_mul;
        logic [31:0] r;
        int          sel;
        for (int n = 0; n < 800; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            op_a = $urandom();
            op_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            if (sel < 1) begin
                set_req(2'b10, 3'b000, 1'b0, 1'b1, op_a, op_b);
            end else begin
                alu_op = 2'($urandom_range(0, 3));
                funct3 = 3'($urandom_range(0, 7));
                funct7_5 = 1'($urandom_range(0, 1));
                funct7_0 = ($urandom_range(0, 7) == 0);
            end
            #1;
            exp_ir = (mcnt == 0) && (!mv || out_ready);
            vectors++;
            if (in_ready !== exp_ir) begin
                miscompares++;
                $display("FAIL rnd_in_ready[%0d]: got %b, required %b", n, in_ready, exp_ir);
            end
            acc = in_valid && exp_ir;
            r = ref_alu(alu_op, funct3, funct7_5, funct7_0, op_a, op_b, 1'b1, ill, is_mul);
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mv = 1'b1;
                    mres = mpend;
                    mill = 1'b0;
                    mzero = (mpend == 32'h0);
                end
            end else begin
                if (mv && out_ready) mv = 1'b0;
                if (acc) begin
                    if (is_mul) begin
                        mcnt = 32;
                        mpend = r;
                    end else begin
                        mv = 1'b1;
                        mres = r;
                        mill = ill;
                        mzero = (r == 32'h0);
                    end
                end
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== mv || busy !== (mcnt > 0) || result !== mres
                || illegal !== mill || zero !== mzero) begin
                miscompares++;
                $display("FAIL rnd_out[%0d]: ov=%b busy=%b res=%h ill=%b zero=%b, required %b %b %h %b %b",
                         n, out_valid, busy, result, illegal, zero, mv, (mcnt > 0), mres, mill, mzero);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_illegal_zero();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
